float_div_mul_stall_ctrl: RTL and testbench
===========================================

FLOAT_DIV_MUL_STALL_CTRL -- requirements
Module: float_div_mul_stall_ctrl

Interface
REQ-001 Parameter: LAT, default 5, pipeline latency of the attached stall-enabled IEEE E8/M23 multiplier, in enabled clock edges.
REQ-002 Parameter: FIFO_DEPTH, default 4, result FIFO entries; power of two, minimum 2.
REQ-003 aclk  input  1  single clock; all state on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand pair accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 in_a, in_b  input  32 each  IEEE single operands {sign, exp[7:0], man[22:0]}.
REQ-008 in_rm  input  3  rounding mode, passed through.
REQ-009 pipe_a_sign/pipe_a_exp/pipe_a_man, pipe_b_sign/pipe_b_exp/pipe_b_man  output  1/8/23 each  field split of in_a/in_b to the multiplier.
REQ-010 pipe_rm  output  3  equals in_rm.
REQ-011 pipe_stall  output  1  drives the multiplier's astall; high freezes all multiplier stages.
REQ-012 pipe_x  input  32  multiplier result.
REQ-013 out_valid  output  1  result available at FIFO head.
REQ-014 out_ready  input  1  result consumed when out_valid and out_ready are both high at a rising edge.
REQ-015 out_x  output  32  FIFO head data.
REQ-016 busy  output  1  high when any in-flight token or any FIFO entry exists.

Function
REQ-017 Pipe operand outputs are combinational copies of in_a/in_b/in_rm; the multiplier captures them on every non-stalled edge regardless of in_valid.
REQ-018 Token register vld[LAT-1:0] tracks in-flight operations; on a non-stalled edge vld[0] <= in_valid & in_ready, vld[k] <= vld[k-1].
REQ-019 On a stalled edge vld holds its value.
REQ-020 pop = out_valid & out_ready; full = (fifo count == FIFO_DEPTH).
REQ-021 pipe_stall = vld[LAT-1] & full & ~pop (combinational path out_ready -> pipe_stall is permitted).
REQ-022 in_ready = ~pipe_stall.
REQ-023 push = vld[LAT-1] & ~pipe_stall; on push, pipe_x is written to the FIFO tail at the same edge.
REQ-024 Simultaneous push and pop at any occupancy, including full: count unchanged, no stall, no data loss.
REQ-025 Pop on empty is impossible (out_valid = count != 0); push on full without pop is impossible (stall).
REQ-026 FIFO pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
REQ-027 Results leave in acceptance order; no reordering, drop, or duplication.
REQ-028 Latency with empty FIFO and no stall: acceptance edge E0, vld[LAT-1] high after E(LAT-1), push at E(LAT), out_valid high after E(LAT) -- LAT+1 cycles.
REQ-029 Throughput: one acceptance per cycle sustained while out_ready stays high.
REQ-030 out_x is FIFO storage read at head pointer; undefined when out_valid low.
REQ-031 busy = (|vld) | (count != 0).

Reset
REQ-032 aresetn low: vld = 0, FIFO pointers and count = 0, immediately and asynchronously.
REQ-033 Outputs during/after reset: out_valid 0, pipe_stall 0, in_ready 1, busy 0.
REQ-034 FIFO data storage is not reset; multiplier contents are not reset and are ignored because vld is cleared.
REQ-035 Reset mid-operation discards all in-flight and queued results; no result from before reset ever appears at out_valid.
REQ-036 Deassertion is synchronised by the system; first acceptance is permitted on the first edge after release.

Verification
REQ-037 Single op: in_a=0x40000000, in_b=0x40400000, rm=0, out_ready=1 -> out_valid high exactly 6 cycles after acceptance, out_x=0x40C00000, busy low the cycle after pop.
REQ-038 Burst: 10 back-to-back ops, out_ready=0 -> 4 entries queued, pipe_stall and in_ready=0 once 5th result reaches vld[4]; 9 accepted total; raise out_ready -> all 9 drain in order, then 10th accepted.
REQ-039 Full with pop: FIFO full, vld[4]=1, out_ready=1 -> pipe_stall=0, push and pop same edge, count stays 4.
REQ-040 Stall freeze: stall for 3 cycles with operands changing on in_a -> no acceptance, vld unchanged, results after release match pre-stall operands only.
REQ-041 Reset mid-flight: 3 ops in flight, 2 queued, assert aresetn low for 1 cycle -> out_valid=0, busy=0, no stale result emerges over the next 10 cycles.
REQ-042 Wrap: 20 ops with out_ready toggling every cycle -> results in order, pointer wrap exercised, no loss.

Source files
------------

// File: rtl/float_div_mul_stall_ctrl.sv
// rtl/float_div_mul_stall_ctrl.sv - stall/handshake controller and result FIFO for a stall-enabled FP multiplier
// Tracks in-flight tokens beside the multiplier and stalls it only when a result has nowhere to go.
module float_div_mul_stall_ctrl #(
  parameter int unsigned LAT        = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_rm,
  output logic        pipe_a_sign,
  output logic [7:0]  pipe_a_exp,
  output logic [22:0] pipe_a_man,
  output logic        pipe_b_sign,
  output logic [7:0]  pipe_b_exp,
  output logic [22:0] pipe_b_man,
  output logic [2:0]  pipe_rm,
  output logic        pipe_stall,
  input  logic [31:0] pipe_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    mem_q [FIFO_DEPTH];
  logic           full, push, pop, accept;

  assign pipe_a_sign = in_a[31];
  assign pipe_a_exp  = in_a[30:23];
  assign pipe_a_man  = in_a[22:0];
  assign pipe_b_sign = in_b[31];
  assign pipe_b_exp  = in_b[30:23];
  assign pipe_b_man  = in_b[22:0];
  assign pipe_rm     = in_rm;

  // A pop frees the slot the oldest token needs, so a full FIFO only stalls without one.
  assign out_valid  = (cnt_q != '0);
  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign pop        = out_valid & out_ready;
  assign pipe_stall = vld_q[LAT-1] & full & ~pop;
  assign in_ready   = ~pipe_stall;
  assign accept     = in_valid & in_ready;
  assign push       = vld_q[LAT-1] & ~pipe_stall;
  assign out_x      = mem_q[rd_ptr_q];
  assign busy       = (|vld_q) | out_valid;

  always_comb begin
    vld_d = vld_q;
    if (!pipe_stall) begin
      vld_d[0] = accept;
      for (int k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; the pointers and count alone decide what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pipe_x;
    end
  end

endmodule

// File: tb/tb_float_div_mul_stall_ctrl.sv
// tb/tb_float_div_mul_stall_ctrl.sv - self-checking bench for float_div_mul_stall_ctrl
// Models the stall-enabled multiplier and a result scoreboard; table rows plus multi-cycle sequences.
module tb_float_div_mul_stall_ctrl;

  localparam int LAT = 5;

  logic        aclk, aresetn;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_rm;
  logic        pipe_a_sign, pipe_b_sign;
  logic [7:0]  pipe_a_exp, pipe_b_exp;
  logic [22:0] pipe_a_man, pipe_b_man;
  logic [2:0]  pipe_rm;
  logic        pipe_stall;
  logic [31:0] pipe_x;
  logic        out_valid, out_ready;
  logic [31:0] out_x;
  logic        busy;

  float_div_mul_stall_ctrl #(.LAT(LAT), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
    .pipe_a_sign(pipe_a_sign), .pipe_a_exp(pipe_a_exp), .pipe_a_man(pipe_a_man),
    .pipe_b_sign(pipe_b_sign), .pipe_b_exp(pipe_b_exp), .pipe_b_man(pipe_b_man),
    .pipe_rm(pipe_rm), .pipe_stall(pipe_stall), .pipe_x(pipe_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc, n_pop, op;
  logic last_acc;
  logic [31:0] exp_q[$];

  function automatic real s2r(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:0] == 31'd0) return 0.0;
    e = {3'b000, a[30:23]} + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) * s2r(b));
  endfunction

  function automatic logic [31:0] opa(input int i);
    return 32'h3F800000 | (32'(i) << 18);
  endfunction

  function automatic logic [31:0] opb(input int i);
    return i[0] ? 32'hC0400000 : 32'h40000000;
  endfunction

  // Multiplier stand-in: captures the split fields on every non-stalled edge.
  logic [31:0] mstage [LAT];
  always @(posedge aclk) begin
    if (!pipe_stall) begin
      mstage[0] <= fmul({pipe_a_sign, pipe_a_exp, pipe_a_man}, {pipe_b_sign, pipe_b_exp, pipe_b_man});
      for (int k = 1; k < LAT; k++) mstage[k] <= mstage[k-1];
    end
  end
  assign pipe_x = mstage[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    logic acc, pp;
    #1;
    acc = in_valid & in_ready;
    pp  = out_valid & out_ready;
    last_acc = acc;
    if (pp) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h want none", out_x);
      end else begin
        chk("result_order", out_x, exp_q.pop_front());
      end
    end
    if (acc) begin
      n_acc++;
      exp_q.push_back(fmul(in_a, in_b));
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.delete();
    n_acc = 0; n_pop = 0; op = 0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] a, b;
    logic [2:0]  rm;
    logic        ordy;
    logic        e_ir, e_ov, e_st, e_busy;
    logic        cx;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h40000000, 32'h40400000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'hBF800000, 32'h00000000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h12345678, 32'h87654321, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 32'h7F7FFFFF, 32'h00800000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h00000000, 32'h00000000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h00000000, 32'h00000000, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40C00000};
    tbl[7] = '{1'b0, 32'h00000000, 32'h00000000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    in_a = '0; in_b = '0; in_rm = '0;
    do_reset();

    // Single operation: latency, result value, busy dropping after the pop.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].iv; in_a = tbl[i].a; in_b = tbl[i].b;
      in_rm = tbl[i].rm; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_pipe_stall", i), pipe_stall, tbl[i].e_st);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_pipe_rm", i), pipe_rm, tbl[i].rm);
      chk($sformatf("tbl%0d_fields_a", i), {pipe_a_sign, pipe_a_exp, pipe_a_man}, tbl[i].a);
      chk($sformatf("tbl%0d_fields_b", i), {pipe_b_sign, pipe_b_exp, pipe_b_man}, tbl[i].b);
      if (tbl[i].cx) chk($sformatf("tbl%0d_out_x", i), out_x, tbl[i].ex);
      cycle();
    end

    // Burst into a blocked output: four queued, fifth token stalls, nine accepted.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'b1; in_a = opa(op); in_b = opb(op);
      cycle();
      if (last_acc) op++;
    end
    chk("burst_accepted", n_acc, 9);
    for (int c = 0; c < 3; c++) begin
      in_a = $urandom; in_b = $urandom;
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_pipe_stall", pipe_stall, 1'b1);
      chk("stall_busy", busy, 1'b1);
      cycle();
    end
    chk("freeze_accepted", n_acc, 9);

    // Full FIFO with pop: no stall, push and pop on the same edge.
    in_a = opa(op); in_b = opb(op); out_ready = 1'b1;
    #1;
    chk("fullpop_stall", pipe_stall, 1'b0);
    chk("fullpop_in_ready", in_ready, 1'b1);
    cycle();
    if (last_acc) op++;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fullpop_count_kept", pipe_stall, 1'b1);
    cycle();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n_pop < 10; c++) cycle();
    chk("burst_drained", n_pop, 10);
    chk("burst_total", n_acc, 10);
    chk("burst_queue_empty", exp_q.size(), 0);

    // Reset with three in flight and two queued.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = opa(c + 20); in_b = opb(c);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    #1;
    chk("pre_reset_out_valid", out_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pipe_stall", pipe_stall, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("post_reset_no_stale", out_valid, 1'b0);
      cycle();
    end

    // Toggling out_ready over 20 ops wraps the pointers several times.
    n_acc = 0; n_pop = 0; op = 0;
    for (int c = 0; c < 200 && n_pop < 20; c++) begin
      in_valid = (op < 20); in_a = opa(op); in_b = opb(op + 1);
      out_ready = (c % 2 == 1);
      cycle();
      if (last_acc) op++;
    end
    chk("wrap_accepted", n_acc, 20);
    chk("wrap_popped", n_pop, 20);
    #1;
    chk("wrap_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
